us_arp_rx: RTL and testbench

//  ARP receive parser; the receive-side counterpart of the ARP transmitter. Takes the 28-byte ARP payload (Ethernet header already stripped, pad allowed) as 64-bit AXIS.

---
 rtl/us_arp_pkg.sv | 42 ++++
 rtl/us_arp_rx_if.sv | 11 +
 rtl/us_arp_rx.sv | 201 ++++++++++++++++++++
 tb/tb_us_arp_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/us_arp_pkg.sv
// ARP field constants and beat layout shared by the ARP receive parser and transmitter.
// Beats are 64 bits wide with byte 0 of the beat in [63:56].
package us_arp_pkg;

  localparam logic [15:0] ArpHtypeEth    = 16'h0001;
  localparam logic [15:0] ArpPtypeIpv4   = 16'h0800;
  localparam logic [7:0]  ArpHlenEth     = 8'h06;
  localparam logic [7:0]  ArpPlenIpv4    = 8'h04;
  localparam logic [15:0] ArpOperRequest = 16'h0001;
  localparam logic [15:0] ArpOperReply   = 16'h0002;

  // Field LSB positions inside each payload beat.
  localparam int unsigned B0HtypeLsb = 48;
  localparam int unsigned B0PtypeLsb = 32;
  localparam int unsigned B0HlenLsb  = 24;
  localparam int unsigned B0PlenLsb  = 16;
  localparam int unsigned B0OperLsb  = 0;
  localparam int unsigned B1ShaLsb   = 16;
  localparam int unsigned B1SpaHiLsb = 0;
  localparam int unsigned B2SpaLoLsb = 48;
  localparam int unsigned B3TpaLsb   = 32;

  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StBeat1 = 6'b000010,
    StBeat2 = 6'b000100,
    StBeat3 = 6'b001000,
    StDrain = 6'b010000,
    StCheck = 6'b100000
  } arp_rx_state_e;

  function automatic logic arp_hdr_ok(input logic [63:0] beat);
    logic [15:0] oper;
    oper = beat[B0OperLsb +: 16];
    return (beat[B0HtypeLsb +: 16] == ArpHtypeEth) &&
           (beat[B0PtypeLsb +: 16] == ArpPtypeIpv4) &&
           (beat[B0HlenLsb +: 8] == ArpHlenEth) &&
           (beat[B0PlenLsb +: 8] == ArpPlenIpv4) &&
           ((oper == ArpOperRequest) || (oper == ArpOperReply));
  endfunction

endpackage

// File: rtl/us_arp_rx_if.sv
// 64-bit AXI-Stream link carrying ARP payload beats.
interface us_arp_rx_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/us_arp_rx.sv
// ARP receive parser: validates the 28-byte payload, raises held reply requests for
// requests to our IP and pulses a cache-update strobe for replies.
module us_arp_rx
  import us_arp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 999999
) (
  input  logic              rx_axis_aclk,
  input  logic              rx_axis_aresetn,
  us_arp_rx_if.slave        arp_rx_axis,
  input  logic [31:0]       local_ip_addr,
  output logic              arp_reply_req,
  input  logic              arp_reply_ack,
  output logic [47:0]       reply_dst_mac_addr,
  output logic [31:0]       reply_dst_ip_addr,
  output logic              arp_found,
  output logic [47:0]       arp_found_mac,
  output logic [31:0]       arp_found_ip,
  output logic              arp_rx_drop,
  output logic [15:0]       arp_rx_drop_cnt
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;

  arp_rx_state_e state_q, state_d;
  logic          ready_q, ready_d;
  logic [15:0]   oper_q, oper_d;
  logic [47:0]   sha_q, sha_d;
  logic [31:0]   spa_q, spa_d;
  logic [31:0]   tpa_q, tpa_d;
  logic          good_q, good_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic          drop_q, drop_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          req_q, req_d;
  logic [47:0]   reply_mac_q, reply_mac_d;
  logic [31:0]   reply_ip_q, reply_ip_d;
  logic          found_q, found_d;
  logic [47:0]   found_mac_q, found_mac_d;
  logic [31:0]   found_ip_q, found_ip_d;

  logic        beat;
  logic [63:0] data;
  logic        last;
  logic        unused_tkeep;

  assign beat         = arp_rx_axis.tvalid & ready_q;
  assign data         = arp_rx_axis.tdata;
  assign last         = arp_rx_axis.tlast;
  assign unused_tkeep = ^arp_rx_axis.tkeep;

  always_comb begin
    state_d     = state_q;
    oper_d      = oper_q;
    sha_d       = sha_q;
    spa_d       = spa_q;
    tpa_d       = tpa_q;
    good_d      = good_q;
    tmo_d       = '0;
    drop_d      = 1'b0;
    req_d       = req_q;
    reply_mac_d = reply_mac_q;
    reply_ip_d  = reply_ip_q;
    found_d     = 1'b0;
    found_mac_d = found_mac_q;
    found_ip_d  = found_ip_q;

    if (arp_reply_ack) begin
      req_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (beat) begin
          oper_d = data[B0OperLsb +: 16];
          good_d = arp_hdr_ok(data);
          if (!arp_hdr_ok(data)) begin
            drop_d  = 1'b1;
            state_d = last ? StIdle : StDrain;
          end else if (last) begin
            drop_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StBeat1;
          end
        end
      end
      StBeat1: begin
        if (beat) begin
          sha_d         = data[B1ShaLsb +: 48];
          spa_d[31:16]  = data[B1SpaHiLsb +: 16];
          drop_d        = last;
          state_d       = last ? StIdle : StBeat2;
        end
      end
      StBeat2: begin
        if (beat) begin
          spa_d[15:0] = data[B2SpaLoLsb +: 16];
          drop_d      = last;
          state_d     = last ? StIdle : StBeat3;
        end
      end
      StBeat3: begin
        if (beat) begin
          tpa_d   = data[B3TpaLsb +: 32];
          state_d = last ? StCheck : StDrain;
        end
      end
      StDrain: begin
        if (beat && last) begin
          state_d = good_q ? StCheck : StIdle;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (tpa_q != local_ip_addr) begin
          drop_d = 1'b1;
        end else if (oper_q == ArpOperRequest) begin
          // A pending request, or one being acked this cycle, blocks the new one.
          if (req_q || arp_reply_ack) begin
            drop_d = 1'b1;
          end else begin
            req_d       = 1'b1;
            reply_mac_d = sha_q;
            reply_ip_d  = spa_q;
          end
        end else begin
          found_d     = 1'b1;
          found_mac_d = sha_q;
          found_ip_d  = spa_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q inside {StBeat1, StBeat2, StBeat3, StDrain}) && !arp_rx_axis.tvalid) begin
      if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        drop_d  = 1'b1;
        state_d = StIdle;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end

    ready_d = (state_d != StCheck);

    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      oper_q      <= '0;
      sha_q       <= '0;
      spa_q       <= '0;
      tpa_q       <= '0;
      good_q      <= 1'b0;
      tmo_q       <= '0;
      drop_q      <= 1'b0;
      drop_cnt_q  <= '0;
      req_q       <= 1'b0;
      reply_mac_q <= '0;
      reply_ip_q  <= '0;
      found_q     <= 1'b0;
      found_mac_q <= '0;
      found_ip_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      oper_q      <= oper_d;
      sha_q       <= sha_d;
      spa_q       <= spa_d;
      tpa_q       <= tpa_d;
      good_q      <= good_d;
      tmo_q       <= tmo_d;
      drop_q      <= drop_d;
      drop_cnt_q  <= drop_cnt_d;
      req_q       <= req_d;
      reply_mac_q <= reply_mac_d;
      reply_ip_q  <= reply_ip_d;
      found_q     <= found_d;
      found_mac_q <= found_mac_d;
      found_ip_q  <= found_ip_d;
    end
  end

  assign arp_rx_axis.tready = ready_q;
  assign arp_reply_req      = req_q;
  assign reply_dst_mac_addr = reply_mac_q;
  assign reply_dst_ip_addr  = reply_ip_q;
  assign arp_found          = found_q;
  assign arp_found_mac      = found_mac_q;
  assign arp_found_ip       = found_ip_q;
  assign arp_rx_drop        = drop_q;
  assign arp_rx_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_us_arp_rx.sv
// Directed bench for us_arp_rx: frame vector table plus hand-built pending, timeout and reset cases.
module tb_us_arp_rx;

  localparam logic [31:0] LocalIp = 32'hC0A80190;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] local_ip;
  logic        ack;
  logic        req;
  logic [47:0] reply_mac;
  logic [31:0] reply_ip;
  logic        found;
  logic [47:0] found_mac;
  logic [31:0] found_ip;
  logic        drop;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int found_seen = 0;
  int drop_seen = 0;

  us_arp_rx_if axis ();

  us_arp_rx #(.TIMEOUT_CYCLES(16)) dut (
    .rx_axis_aclk       (clk),
    .rx_axis_aresetn    (rst_n),
    .arp_rx_axis        (axis),
    .local_ip_addr      (local_ip),
    .arp_reply_req      (req),
    .arp_reply_ack      (ack),
    .reply_dst_mac_addr (reply_mac),
    .reply_dst_ip_addr  (reply_ip),
    .arp_found          (found),
    .arp_found_mac      (found_mac),
    .arp_found_ip       (found_ip),
    .arp_rx_drop        (drop),
    .arp_rx_drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (found) found_seen <= found_seen + 1;
    if (drop) drop_seen <= drop_seen + 1;
  end

  typedef struct {
    logic [383:0] b;
    int           n;
    bit           rq;
    bit           fd;
    int           dr;
    logic [47:0]  mac;
    logic [31:0]  ip;
    logic [15:0]  cnt;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [383:0] mkf(input logic [15:0] ptype, input logic [15:0] oper,
                                       input logic [47:0] sha, input logic [31:0] spa,
                                       input logic [31:0] tpa);
    logic [383:0] f;
    f = {64'hDEADBEEF_0BADF00D, 64'hA5A5A5A5_5A5A5A5A, 64'h0, 64'h0, 64'h0, 64'h0};
    f[63:0]    = {16'h0001, ptype, 8'h06, 8'h04, oper};
    f[127:64]  = {sha, spa[31:16]};
    f[191:128] = {spa[15:0], 48'h0};
    f[255:192] = {tpa, 32'h1234_5678};
    return f;
  endfunction

  function automatic vec_t mkv(input logic [383:0] b, input int n, input bit rq, input bit fd,
                               input int dr, input logic [47:0] mac, input logic [31:0] ip,
                               input logic [15:0] cnt);
    vec_t v;
    v.b = b; v.n = n; v.rq = rq; v.fd = fd; v.dr = dr; v.mac = mac; v.ip = ip; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [383:0] b, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int g;
      @(negedge clk);
      axis.tdata  = b[i*64 +: 64];
      axis.tvalid = 1'b1;
      axis.tlast  = with_last && (i == n - 1);
      g = 0;
      while (!axis.tready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) chk("tready wait", {63'b0, axis.tready}, 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [383:0] r1, r2, rp, lft;
    int d0, f0;

    r1 = mkf(16'h0800, 16'h0001, 48'h001122334455, 32'hC0A80195, LocalIp);
    r2 = mkf(16'h0800, 16'h0001, 48'h665544332211, 32'hC0A80196, LocalIp);
    rp = mkf(16'h0800, 16'h0002, 48'hAC1445FFAFC4, 32'hC0A80101, LocalIp);

    vecs[0] = mkv(r1, 4, 1, 0, 0, 48'h001122334455, 32'hC0A80195, 16'd0);
    vecs[1] = mkv(rp, 6, 0, 1, 0, 48'hAC1445FFAFC4, 32'hC0A80101, 16'd0);
    vecs[2] = mkv(mkf(16'h86DD, 16'h0001, 48'h001122334455, 32'hC0A80195, LocalIp),
                  4, 0, 0, 1, 48'h0, 32'h0, 16'd1);
    vecs[3] = mkv(mkf(16'h0800, 16'h0001, 48'h001122334455, 32'hC0A80195, 32'hC0A80199),
                  4, 0, 0, 1, 48'h0, 32'h0, 16'd2);
    vecs[4] = mkv(r1, 2, 0, 0, 1, 48'h0, 32'h0, 16'd3);
    vecs[5] = mkv(mkf(16'h0800, 16'h0003, 48'h001122334455, 32'hC0A80195, LocalIp),
                  1, 0, 0, 1, 48'h0, 32'h0, 16'd4);
    vecs[6] = mkv(r1, 1, 0, 0, 1, 48'h0, 32'h0, 16'd5);
    vecs[7] = mkv(mkf(16'h0800, 16'h0001, 48'h0A0B0C0D0E0F, 32'h0A000005, LocalIp),
                  5, 1, 0, 0, 48'h0A0B0C0D0E0F, 32'h0A000005, 16'd5);

    rst_n       = 1'b0;
    local_ip    = LocalIp;
    ack         = 1'b0;
    axis.tdata  = '0;
    axis.tkeep  = 8'hFF;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset tready", {63'b0, axis.tready}, 64'd0);
    chk("reset req", {63'b0, req}, 64'd0);
    chk("reset found", {63'b0, found}, 64'd0);
    chk("reset drop", {63'b0, drop}, 64'd0);
    chk("reset drop_cnt", {48'b0, drop_cnt}, 64'd0);
    chk("reset reply_mac", {16'b0, reply_mac}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("tready before first clock", {63'b0, axis.tready}, 64'd0);
    @(negedge clk);
    chk("tready after first clock", {63'b0, axis.tready}, 64'd1);

    for (int i = 0; i < 8; i++) begin
      d0 = drop_seen;
      f0 = found_seen;
      send(vecs[i].b, vecs[i].n, 1'b1);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d req", i), {63'b0, req}, {63'b0, vecs[i].rq});
      chk($sformatf("v%0d found pulses", i), 64'(found_seen - f0), 64'(vecs[i].fd));
      chk($sformatf("v%0d drop pulses", i), 64'(drop_seen - d0), 64'(vecs[i].dr));
      chk($sformatf("v%0d drop_cnt", i), {48'b0, drop_cnt}, {48'b0, vecs[i].cnt});
      if (vecs[i].rq) begin
        chk($sformatf("v%0d reply mac", i), {16'b0, reply_mac}, {16'b0, vecs[i].mac});
        chk($sformatf("v%0d reply ip", i), {32'b0, reply_ip}, {32'b0, vecs[i].ip});
        ack_pulse();
        chk($sformatf("v%0d req after ack", i), {63'b0, req}, 64'd0);
      end
      if (vecs[i].fd) begin
        chk($sformatf("v%0d found mac", i), {16'b0, found_mac}, {16'b0, vecs[i].mac});
        chk($sformatf("v%0d found ip", i), {32'b0, found_ip}, {32'b0, vecs[i].ip});
      end
    end

    // Request latency, then a second request while the first is pending.
    send(r1, 4, 1'b1);
    chk("req one clock after tlast", {63'b0, req}, 64'd0);
    @(negedge clk);
    chk("req two clocks after tlast", {63'b0, req}, 64'd1);
    repeat (3) @(negedge clk);
    d0 = drop_seen;
    send(r2, 4, 1'b1);
    repeat (4) @(negedge clk);
    chk("pending second drop", 64'(drop_seen - d0), 64'd1);
    chk("pending req held", {63'b0, req}, 64'd1);
    chk("pending mac kept", {16'b0, reply_mac}, 64'h001122334455);
    chk("pending ip kept", {32'b0, reply_ip}, 64'hC0A80195);
    repeat (5) @(negedge clk);
    ack_pulse();
    chk("pending req cleared", {63'b0, req}, 64'd0);
    chk("pending drop_cnt", {48'b0, drop_cnt}, 64'd6);

    // Stall after B1: the 16th idle cycle aborts the frame.
    d0 = drop_seen;
    send(r1, 2, 1'b0);
    repeat (15) @(negedge clk);
    chk("timeout not early", 64'(drop_seen - d0), 64'd0);
    chk("timeout drop low at 15", {63'b0, drop}, 64'd0);
    @(negedge clk);
    chk("timeout drop at 16", {63'b0, drop}, 64'd1);
    repeat (2) @(negedge clk);
    f0 = found_seen;
    send(rp, 4, 1'b1);
    repeat (4) @(negedge clk);
    chk("post-timeout found", 64'(found_seen - f0), 64'd1);
    chk("post-timeout found mac", {16'b0, found_mac}, 64'hAC1445FFAFC4);
    chk("post-timeout drop_cnt", {48'b0, drop_cnt}, 64'd7);

    // Asynchronous reset during B2; leftover B2/B3 must drain as one drop.
    send(r1, 2, 1'b0);
    @(negedge clk);
    axis.tdata  = r1[191:128];
    axis.tvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-frame reset drop_cnt", {48'b0, drop_cnt}, 64'd0);
    chk("mid-frame reset tready", {63'b0, axis.tready}, 64'd0);
    chk("mid-frame reset found_mac", {16'b0, found_mac}, 64'd0);
    @(negedge clk);
    axis.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    lft = '0;
    lft[63:0]   = r1[191:128];
    lft[127:64] = r1[255:192];
    d0 = drop_seen;
    send(lft, 2, 1'b1);
    repeat (4) @(negedge clk);
    chk("leftover drop pulses", 64'(drop_seen - d0), 64'd1);
    chk("leftover drop_cnt", {48'b0, drop_cnt}, 64'd1);
    chk("leftover no req", {63'b0, req}, 64'd0);
    send(r2, 4, 1'b1);
    repeat (4) @(negedge clk);
    chk("post-reset req", {63'b0, req}, 64'd1);
    chk("post-reset reply mac", {16'b0, reply_mac}, 64'h665544332211);
    chk("post-reset reply ip", {32'b0, reply_ip}, 64'hC0A80196);
    ack_pulse();
    chk("post-reset req cleared", {63'b0, req}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
